// File: rtl/adder_nbits_pipeline_param.sv
// -----------------------------------------------------------------------------
// adder_nbits_pipeline_param
//   Pipelined WIDTH-bit adder/subtractor with a valid/ready handshake on both
//   sides. The carry chain is cut into STAGES segments of SEG = WIDTH/STAGES
//   bits. Each segment is added in its own register stage, so the result
//   appears STAGES cycles after the beat is accepted.
//
//   Ports
//     clk        clock, all state on rising edge
//     rst        asynchronous active-low reset
//     in_valid   operand beat valid
//     in_ready   block accepts a beat this cycle (= !out_valid || out_ready)
//     a, b       operands (WIDTH)
//     cin        carry-in, ignored when sub=1
//     sub        1: a-b, 0: a+b+cin
//     out_valid  result valid
//     out_ready  consumer accepts the result this cycle
//     sum        result (WIDTH)
//     cout       carry-out of the MSB (for subtract: 1 = no borrow)
//     ovf        two's-complement signed overflow
// -----------------------------------------------------------------------------

// One carry-chain segment. Adds slice IDX of the operand word and b, plus the
// incoming carry. The sum bits are written back into the same slice of the
// word, so the lower slices of acc hold finished result bits and the upper
// slices still hold operand A.
module adder_seg #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4,
   parameter int IDX   = 0
) (
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             c_i,
   output logic [WIDTH-1:0] acc_o,
   output logic             c_o
);
   localparam int               SH   = IDX * SEG;
   localparam logic [WIDTH-1:0] MASK = WIDTH'({SEG{1'b1}}) << SH;

   logic [SEG-1:0] seg_a, seg_b;
   logic [SEG:0]   seg_s;

   assign seg_a = SEG'(acc_i >> SH);
   assign seg_b = SEG'(b_i >> SH);
   assign seg_s = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, c_i};
   assign acc_o = (acc_i & ~MASK) | (WIDTH'(seg_s[SEG-1:0]) << SH);
   assign c_o   = seg_s[SEG];
endmodule

module adder_nbits_pipeline_param #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int SEG = WIDTH / STAGES;

   // Index 0 of each pipe is the combinational input; index k (k>=1) is the
   // register after segment k-1 has been added.
   logic [STAGES:0]              vld_pipe;
   logic [STAGES:0]              c_pipe;
   logic [STAGES:0]              sa_pipe;   // delayed sign of A
   logic [STAGES:0]              sb_pipe;   // delayed sign of effective B
   logic [STAGES:0][WIDTH-1:0]   acc_pipe;  // result below, operand A above
   logic [STAGES-1:0][WIDTH-1:0] b_pipe;    // effective B, not needed after last add

   logic [STAGES-1:0][WIDTH-1:0] acc_nxt;
   logic [STAGES-1:0]            c_nxt;

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c0;

   // Subtract is a + ~b + 1; cin has no effect in that mode.
   assign b_eff = sub ? ~b : b;
   assign c0    = sub ? 1'b1 : cin;

   // Whole pipe advances together; a stalled output freezes everything.
   assign out_valid = vld_pipe[STAGES];
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;

   assign vld_pipe[0] = in_valid;
   assign c_pipe[0]   = c0;
   assign sa_pipe[0]  = a[WIDTH-1];
   assign sb_pipe[0]  = b_eff[WIDTH-1];
   assign acc_pipe[0] = a;
   assign b_pipe[0]   = b_eff;

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      adder_seg #(
         .WIDTH (WIDTH),
         .SEG   (SEG),
         .IDX   (k)
      ) u_seg (
         .acc_i (acc_pipe[k]),
         .b_i   (b_pipe[k]),
         .c_i   (c_pipe[k]),
         .acc_o (acc_nxt[k]),
         .c_o   (c_nxt[k])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe[STAGES:1] <= '0;
         c_pipe[STAGES:1]   <= '0;
         sa_pipe[STAGES:1]  <= '0;
         sb_pipe[STAGES:1]  <= '0;
         acc_pipe[STAGES:1] <= '0;
      end else if (en) begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         c_pipe[STAGES:1]   <= c_nxt;
         sa_pipe[STAGES:1]  <= sa_pipe[STAGES-1:0];
         sb_pipe[STAGES:1]  <= sb_pipe[STAGES-1:0];
         acc_pipe[STAGES:1] <= acc_nxt;
      end
   end

   // B only has to travel as far as the last segment adder.
   if (STAGES > 1) begin : g_bpipe
      always_ff @(posedge clk or negedge rst) begin
         if (!rst)
            b_pipe[STAGES-1:1] <= '0;
         else if (en)
            b_pipe[STAGES-1:1] <= b_pipe[STAGES-2:0];
      end
   end

   assign sum  = acc_pipe[STAGES];
   assign cout = c_pipe[STAGES];
   // Overflow only when both operand signs agree and the result sign differs.
   assign ovf  = (sa_pipe[STAGES] == sb_pipe[STAGES]) && (sum[WIDTH-1] != sa_pipe[STAGES]);
endmodule

// File: tb/tb_adder_nbits_pipeline_param.sv
// -----------------------------------------------------------------------------
// tb_adder_nbits_pipeline_param
//   Three instances (16/4, 8/1, 32/8) share clock, reset and operand buses;
//   each has its own in_valid / out_ready. A signed/unsigned arithmetic model
//   fills a per-instance expectation queue on every accepted beat. A single
//   negedge monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_adder_nbits_pipeline_param;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  iv   = '0;
   logic [2:0]  ordy = '0;
   logic [31:0] a_d  = '0;
   logic [31:0] b_d  = '0;
   logic        cin_d = 1'b0;
   logic        sub_d = 1'b0;

   logic [2:0]  irdy, ov, co, of;
   logic [15:0] s0;
   logic [7:0]  s1;
   logic [31:0] s2;

   adder_nbits_pipeline_param #(.WIDTH(16), .STAGES(4)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
      .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin_d), .sub(sub_d),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]));

   adder_nbits_pipeline_param #(.WIDTH(8), .STAGES(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
      .a(a_d[7:0]), .b(b_d[7:0]), .cin(cin_d), .sub(sub_d),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]));

   adder_nbits_pipeline_param #(.WIDTH(32), .STAGES(8)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
      .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
      .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int passed = 0;
   int total  = 0;

   typedef struct {
      int          cyc;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   int          out_cnt  [3];
   logic [31:0] last_sum [3];
   logic        last_cout[3];
   logic        last_ovf [3];
   int          last_lat [3];

   function automatic int wid(int i);
      case (i) 0: return 16; 1: return 8; default: return 32; endcase
   endfunction

   function automatic int stg(int i);
      case (i) 0: return 4; 1: return 1; default: return 8; endcase
   endfunction

   function automatic logic [31:0] sumv(int i);
      case (i) 0: return {16'h0, s0}; 1: return {24'h0, s1}; default: return s2; endcase
   endfunction

   function automatic int qsize(int i);
      case (i) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
   endfunction

   function automatic void qpush(int i, exp_t e);
      case (i) 0: q0.push_back(e); 1: q1.push_back(e); default: q2.push_back(e); endcase
   endfunction

   function automatic exp_t qpop(int i);
      case (i) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
   endfunction

   // Reference: signed and unsigned integer arithmetic in w bits.
   function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic c, logic s);
      exp_t   e;
      longint m, au, bu, as_, bs, r, u;
      m   = longint'(1) << w;
      au  = longint'(a) & (m - 1);
      bu  = longint'(b) & (m - 1);
      as_ = (au >= m / 2) ? au - m : au;
      bs  = (bu >= m / 2) ? bu - m : bu;
      r   = s ? as_ - bs : as_ + bs + longint'(c);
      u   = s ? au - bu  : au + bu + longint'(c);
      e.ovf  = (r < -(m / 2)) || (r >= m / 2);
      e.cout = s ? (au >= bu) : (u >= m);
      e.sum  = 32'(u & (m - 1));
      e.cyc  = 0;
      return e;
   endfunction

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
   endtask

   task automatic fail_now(string nm, string why);
      total++;
      $display("FAIL %s: %s", nm, why);
   endtask

   // Scoreboard: push on accepted beats, pop and compare on accepted results.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            if (iv[i] && irdy[i]) begin
               e = model(wid(i), a_d, b_d, cin_d, sub_d);
               e.cyc = cyc;
               qpush(i, e);
            end
            if (ov[i] && ordy[i]) begin
               out_cnt[i]++;
               if (qsize(i) == 0) begin
                  fail_now($sformatf("sb_extra%0d", i), $sformatf("got %0h expected no result", sumv(i)));
               end else begin
                  e = qpop(i);
                  chk($sformatf("sb_sum%0d", i),  64'(sumv(i)), 64'(e.sum));
                  chk($sformatf("sb_cout%0d", i), 64'(co[i]),   64'(e.cout));
                  chk($sformatf("sb_ovf%0d", i),  64'(of[i]),   64'(e.ovf));
                  last_sum[i]  = sumv(i);
                  last_cout[i] = co[i];
                  last_ovf[i]  = of[i];
                  last_lat[i]  = cyc - e.cyc;
               end
            end
         end
      end
   end

   // Present one beat (called at posedge+1) and hold it until accepted.
   task automatic drive_beat(int i, logic [31:0] a, logic [31:0] b, logic c, logic s);
      int  n;
      bit  acc;
      a_d = a; b_d = b; cin_d = c; sub_d = s;
      iv[i] = 1'b1;
      n = 0; acc = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         if (irdy[i]) acc = 1;
         n++;
      end
      if (!acc) fail_now("accept_timeout", $sformatf("dut%0d in_ready stuck at 0, expected 1", i));
      @(posedge clk); #1;
      iv[i] = 1'b0;
   endtask

   task automatic check_one(int i, logic [31:0] a, logic [31:0] b, logic c, logic s,
                            logic [31:0] es, logic ec, logic eo, string nm);
      int n0, n;
      ordy[i] = 1'b1;
      n0 = out_cnt[i];
      drive_beat(i, a, b, c, s);
      n = 0;
      while (out_cnt[i] == n0 && n < 40) begin @(posedge clk); n++; end
      if (out_cnt[i] == n0) begin
         fail_now(nm, $sformatf("dut%0d no result, expected %0h", i, es));
      end else begin
         chk($sformatf("%s_sum%0d", nm, i),  64'(last_sum[i]),  64'(es));
         chk($sformatf("%s_cout%0d", nm, i), 64'(last_cout[i]), 64'(ec));
         chk($sformatf("%s_ovf%0d", nm, i),  64'(last_ovf[i]),  64'(eo));
         chk($sformatf("%s_lat%0d", nm, i),  64'(last_lat[i]),  64'(stg(i)));
      end
      @(posedge clk); #1;
   endtask

   task automatic drain(int i);
      int n = 0;
      ordy[i] = 1'b1;
      while ((qsize(i) != 0 || ov[i]) && n < 200) begin @(posedge clk); n++; end
      #1;
      chk($sformatf("drain_empty%0d", i), 64'(qsize(i)), 64'd0);
   endtask

   task automatic rand_traffic(int i, int nb);
      bit done;
      int start;
      done  = 0;
      start = out_cnt[i];
      fork
         begin
            for (int k = 0; k < nb; k++) begin
               int g = $urandom_range(0, 2);
               repeat (g) begin @(posedge clk); #1; end
               drive_beat(i, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               ordy[i] = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain(i);
      chk($sformatf("rand_count%0d", i), 64'(out_cnt[i] - start), 64'(nb));
   endtask

   initial begin
      logic [31:0] mask, top, frozen;
      exp_t        m;
      int          start;

      for (int i = 0; i < 3; i++) begin
         out_cnt[i] = 0; last_sum[i] = '0; last_cout[i] = 0; last_ovf[i] = 0; last_lat[i] = 0;
      end

      // Hand-computed values that pin the reference model itself.
      m = model(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0);
      chk("model_pin_wrap", {m.ovf, m.cout, m.sum}, {1'b0, 1'b1, 32'h0000});
      m = model(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
      chk("model_pin_ovf", {m.ovf, m.cout, m.sum}, {1'b1, 1'b0, 32'h8000});
      m = model(16, 32'h0005, 32'h0007, 1'b1, 1'b1);
      chk("model_pin_sub", {m.ovf, m.cout, m.sum}, {1'b0, 1'b0, 32'hFFFE});

      // Reset state.
      #1;
      chk("rst_out_valid", 64'(ov), 64'd0);
      chk("rst_in_ready",  64'(irdy), 64'h7);
      chk("rst_cout",      64'(co), 64'd0);
      chk("rst_ovf",       64'(of), 64'd0);
      chk("rst_sum",       {s2, s1, s0}, 64'd0);
      ordy = 3'b111;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;

      // Directed arithmetic and latency on all three configurations.
      for (int i = 0; i < 3; i++) begin
         mask = (wid(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(i)) - 32'd1);
         top  = 32'd1 << (wid(i) - 1);
         check_one(i, mask,       32'd1, 1'b0, 1'b0, 32'd0,        1'b1, 1'b0, "wrap");
         check_one(i, top - 1,    32'd1, 1'b0, 1'b0, top,          1'b0, 1'b1, "posovf");
         check_one(i, top,        mask,  1'b0, 1'b0, top - 1,      1'b1, 1'b1, "negovf");
         check_one(i, 32'd5,      32'd7, 1'b1, 1'b1, mask - 32'd1, 1'b0, 1'b0, "subneg");
         check_one(i, top,        32'd1, 1'b0, 1'b1, top - 1,      1'b1, 1'b1, "subovf");
      end

      // 8 back-to-back beats, 3-cycle output stall while the pipe is full.
      start = out_cnt[0];
      ordy[0] = 1'b1;
      fork
         begin
            for (int k = 0; k < 8; k++)
               drive_beat(0, $urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end
         begin
            repeat (6) @(posedge clk);
            #1 ordy[0] = 1'b0;
            @(negedge clk);
            chk("stall_in_ready0", 64'(irdy[0]), 64'd0);
            chk("stall_out_valid0", 64'(ov[0]), 64'd1);
            frozen = sumv(0);
            for (int k = 1; k < 3; k++) begin
               @(negedge clk);
               chk($sformatf("stall_in_ready%0d", k), 64'(irdy[0]), 64'd0);
               chk($sformatf("stall_out_valid%0d", k), 64'(ov[0]), 64'd1);
               chk($sformatf("stall_sum_hold%0d", k), 64'(sumv(0)), 64'(frozen));
            end
            @(posedge clk); #1 ordy[0] = 1'b1;
         end
      join
      drain(0);
      chk("stall_count", 64'(out_cnt[0] - start), 64'd8);

      // Reset with three beats in flight.
      ordy[0] = 1'b1;
      for (int k = 0; k < 3; k++) drive_beat(0, $urandom(), $urandom(), 1'b0, 1'b0);
      #1 rst = 1'b0;
      q0.delete();
      #1;
      chk("midrst_out_valid", 64'(ov[0]), 64'd0);
      chk("midrst_sum",       64'(s0), 64'd0);
      chk("midrst_in_ready",  64'(irdy[0]), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      start = out_cnt[0];
      check_one(0, 32'h1234, 32'h1111, 1'b0, 1'b0, 32'h2345, 1'b0, 1'b0, "postrst");
      repeat (10) @(posedge clk);
      #1 chk("postrst_count", 64'(out_cnt[0] - start), 64'd1);

      // Random traffic with random back-pressure.
      for (int i = 0; i < 3; i++) rand_traffic(i, 30);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/adder_nbits_pipeline_param.md
Name: adder_nbits_pipeline_param

Overview:
- Parametrised pipelined adder/subtractor and successor to the fixed 4-bit combinational/pipelined adders.
- Splits a WIDTH-bit carry chain into STAGES equal segments, one register stage per segment, so it can run at high clock rates.
- Adds valid/ready flow control, carry-in, subtract mode and signed-overflow flag.
- Sits between datapath producers and consumers that use the same handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth and number of carry-chain segments; 1..WIDTH; SEG = WIDTH/STAGES bits per stage.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts operand beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (ignored when sub=1)
sub  input  1  1: compute a-b, 0: compute a+b+cin
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  result
cout  output  1  carry-out of MSB (for sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: rst low asynchronously clears every stage valid bit, carry, operand and partial-sum register to 0. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 while rst is low and after release.
- Operand preparation, combinational at input: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Global enable: en = !out_valid || out_ready. in_ready = en, combinational from out_ready and out_valid. No combinational path from in_valid to in_ready.
- When en=1, all stages advance one position. Stage 0 captures {in_valid, a, b_eff, c0, a[MSB], b_eff[MSB]} if in_valid=1, else a bubble (valid=0; data don't-care).
- When en=0, all stages hold. out_valid, sum, cout and ovf stay stable until accepted.
- Stage k (k=1..STAGES):
  - adds segment k-1 (bits [k*SEG-1:(k-1)*SEG]) of a and b_eff plus the carry from stage k-1;
  - registers the SEG-bit partial sum and the carry;
  - shifts lower finished result segments along unchanged;
  - shifts upper not-yet-added operand segments along unchanged.
- Latency: exactly STAGES cycles from an accepted input (in_valid && in_ready at edge t) to out_valid=1 after edge t+STAGES-1, assuming no stall.
- Throughput: one result per cycle while out_ready=1.
- Bubbles are not compressed. A valid beat behind a bubble still takes STAGES cycles.
- Result: sum = (a + b_eff + c0) mod 2^WIDTH. cout = bit WIDTH of that sum. ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]), using the delayed sign bits.
- Ordering: results leave strictly in acceptance order. No beat is dropped or duplicated under any stall pattern.
- Simultaneous events:
  - output accepted and new input accepted in the same cycle is legal and sustains full rate;
  - in_valid while in_ready=0 is ignored, and the producer must hold the beat.
- STAGES=1: a single registered full-width adder with 1-cycle latency.
- Reset mid-operation discards all in-flight beats. No result from before reset ever appears afterwards.

Test Plan:
- W=16, S=4, a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid high 4 cycles after acceptance with sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0xFFFF, sub=0 -> sum=0x7FFF, cout=1, ovf=1.
- a=0x0005, b=0x0007, sub=1, cin=1 (ignored) -> sum=0xFFFE, cout=0, ovf=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
- Stream 8 back-to-back random beats with out_ready=1, then drop out_ready for 3 cycles while full -> in_ready=0 and sum/out_valid frozen for those 3 cycles. After out_ready returns, all 8 results arrive in order and match the reference model, with no loss or duplicates.
- Pull rst low with 3 beats in flight -> out_valid=0 and sum=0 immediately, without waiting for a clock edge. After release, a single beat 0x1234+0x1111 yields only sum=0x2345 after 4 cycles.
- Re-run scenarios 1-3 with W=8, S=1 and W=32, S=8 -> latency 1 and 8 respectively, with identical arithmetic results.
